// File: rtl/mips_run_monitor_pkg.sv
// Shared types for the MIPS run monitor.
//
// mtc0_code_t     : status codes the program writes through MTC0. They are
//                   shared with the core and the testbench.
// monitor_state_t : run-state of the monitor.
// effective_code  : folds the valid strobe into the code, so a missing
//                   strobe is seen as NOOP.
// is_terminal     : true for the two states that hold until reset.
package mips_run_monitor_pkg;

  typedef enum logic [2:0] {
    MTC0_NOOP  = 3'd0,
    MTC0_DONE  = 3'd1,
    MTC0_FAIL  = 3'd2,
    MTC0_START = 3'd3,
    MTC0_STOP  = 3'd4,
    MTC0_CLEAR = 3'd5,
    MTC0_PASS  = 3'd6
  } mtc0_code_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STOPPED = 3'd2,
    DONE_S  = 3'd3,
    FAIL_S  = 3'd4
  } monitor_state_t;

  // An MTC0 code only matters when its strobe is present. Code 7 is left
  // as-is and is ignored by the decoders through their default branches.
  function automatic mtc0_code_t effective_code(input logic valid, input mtc0_code_t code);
    mtc0_code_t result;
    if (valid) begin
      result = code;
    end else begin
      result = MTC0_NOOP;
    end
    return result;
  endfunction

  // DONE_S and FAIL_S freeze everything until reset.
  function automatic logic is_terminal(input monitor_state_t s);
    logic result;
    case (s)
      DONE_S:  result = 1'b1;
      FAIL_S:  result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mips_run_monitor_if.sv
// Bundle between the MIPS core and its run monitor.
//
// The core side (master) drives:
//   retire_valid, mtc0_valid, mtc0_code
// The core side observes:
//   num_cycles, num_instructions, pass_count, running, done, fail, hang
// The monitor side (slave) has the same signals with the opposite directions.
interface mips_run_monitor_if
  import mips_run_monitor_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int PASS_W = 16
);

  logic              retire_valid;
  logic              mtc0_valid;
  mtc0_code_t        mtc0_code;
  logic [CNT_W-1:0]  num_cycles;
  logic [CNT_W-1:0]  num_instructions;
  logic [PASS_W-1:0] pass_count;
  logic              running;
  logic              done;
  logic              fail;
  logic              hang;

  modport master (
    output retire_valid, mtc0_valid, mtc0_code,
    input  num_cycles, num_instructions, pass_count, running, done, fail, hang
  );

  modport slave (
    input  retire_valid, mtc0_valid, mtc0_code,
    output num_cycles, num_instructions, pass_count, running, done, fail, hang
  );

endinterface

// File: rtl/mips_run_monitor_sat_counter.sv
// Saturating up-counter with a registered output.
//
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset; clears q
//   clr   : synchronous clear; has priority over en
//   en    : count enable; q holds at all-ones once it reaches that value
//   q     : count value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] ONE  = W'(1);

  // Count register: clear wins over enable, and the value stops at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= ZERO;
    end else if (clr) begin
      q <= ZERO;
    end else if (en && (q != ONES)) begin
      q <= q + ONE;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor for the MIPS core: it collects cycle and retired-instruction
// statistics, decodes MTC0 status codes into latched done/fail flags, and
// forces FAIL when the core stops retiring for HANG_LIMIT RUN cycles.
//
// Parameters:
//   CNT_W      : width of the cycle and instruction counters
//   PASS_W     : width of the pass-checkpoint counter
//   HANG_LIMIT : number of idle RUN cycles in a row that trigger FAIL
//                (0 turns the watchdog off)
//   AUTO_START : 1 leaves reset in RUN, 0 leaves reset in IDLE
// Ports:
//   clk   : core clock
//   rst_n : synchronous active-low reset
//   mon   : slave side of mips_run_monitor_if
//           (retire/MTC0 inputs, statistics and status outputs)
module mips_run_monitor
  import mips_run_monitor_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PASS_W     = 16,
  parameter int HANG_LIMIT = 1000000,
  parameter int AUTO_START = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_run_monitor_if.slave     mon
);

  // The idle counter never needs to hold HANG_LIMIT itself. It trips when it
  // is at HANG_LIMIT-1 and the current cycle is idle too.
  localparam int                IDLE_W      = (HANG_LIMIT > 1) ? $clog2(HANG_LIMIT) : 1;
  localparam logic              WD_ON       = (HANG_LIMIT != 0) ? 1'b1 : 1'b0;
  localparam logic [IDLE_W-1:0] IDLE_ZERO   = {IDLE_W{1'b0}};
  localparam logic [IDLE_W-1:0] IDLE_ONE    = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(HANG_LIMIT - 1);
  localparam monitor_state_t    RESET_STATE = (AUTO_START != 0) ? RUN : IDLE;
  localparam logic              RESET_RUN   = (AUTO_START != 0) ? 1'b1 : 1'b0;

  monitor_state_t    state_r;
  monitor_state_t    next_state_s;
  logic              running_r;
  logic              done_r;
  logic              fail_r;
  logic              hang_r;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [IDLE_W-1:0] idle_next_s;

  mtc0_code_t        code_s;
  logic              terminal_s;
  logic              in_run_s;
  logic              clr_s;
  logic              cyc_en_s;
  logic              ins_en_s;
  logic              pass_en_s;
  logic              expire_s;
  logic              hang_evt_s;

  // Decode the current MTC0 code and derive the counter controls.
  // Terminal states ignore every input.
  always_comb begin
    code_s     = effective_code(mon.mtc0_valid, mon.mtc0_code);
    terminal_s = is_terminal(state_r);
    in_run_s   = (state_r == RUN) ? 1'b1 : 1'b0;
    clr_s      = 1'b0;
    pass_en_s  = 1'b0;
    if (!terminal_s) begin
      case (code_s)
        MTC0_CLEAR: clr_s     = 1'b1;
        MTC0_PASS:  pass_en_s = 1'b1;
        default: begin
          clr_s     = 1'b0;
          pass_en_s = 1'b0;
        end
      endcase
    end else begin
      clr_s     = 1'b0;
      pass_en_s = 1'b0;
    end
    cyc_en_s = in_run_s;
    ins_en_s = in_run_s & mon.retire_valid;
  end

  // Watchdog trip condition: this would be the HANG_LIMIT-th idle RUN cycle in a row.
  always_comb begin
    if (WD_ON && in_run_s && !mon.retire_valid && (idle_cnt_r == IDLE_LAST)) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // Next-state decode. In RUN, any explicit code other than NOOP/START/PASS
  // takes precedence over the watchdog, so a DONE/FAIL arriving in the trip
  // cycle is reported as such and hang stays clear.
  always_comb begin
    next_state_s = state_r;
    hang_evt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (code_s == MTC0_START) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        case (code_s)
          MTC0_STOP:  next_state_s = STOPPED;
          MTC0_DONE:  next_state_s = DONE_S;
          MTC0_FAIL:  next_state_s = FAIL_S;
          MTC0_CLEAR: next_state_s = RUN;
          default: begin
            if (expire_s) begin
              next_state_s = FAIL_S;
              hang_evt_s   = 1'b1;
            end else begin
              next_state_s = RUN;
            end
          end
        endcase
      end
      STOPPED: begin
        case (code_s)
          MTC0_START: next_state_s = RUN;
          MTC0_DONE:  next_state_s = DONE_S;
          MTC0_FAIL:  next_state_s = FAIL_S;
          default:    next_state_s = STOPPED;
        endcase
      end
      DONE_S:  next_state_s = DONE_S;
      FAIL_S:  next_state_s = FAIL_S;
      default: next_state_s = FAIL_S;
    endcase
  end

  // The idle streak restarts on a retire, on CLEAR, and whenever the
  // monitor is not staying in RUN.
  always_comb begin
    if (!WD_ON || clr_s || !in_run_s || mon.retire_valid || (next_state_s != RUN)) begin
      idle_next_s = IDLE_ZERO;
    end else begin
      idle_next_s = idle_cnt_r + IDLE_ONE;
    end
  end

  // Monitor FSM and its registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= RESET_STATE;
      running_r <= RESET_RUN;
      done_r    <= 1'b0;
      fail_r    <= 1'b0;
      hang_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      running_r <= (next_state_s == RUN)    ? 1'b1 : 1'b0;
      done_r    <= (next_state_s == DONE_S) ? 1'b1 : 1'b0;
      fail_r    <= (next_state_s == FAIL_S) ? 1'b1 : 1'b0;
      hang_r    <= hang_r | hang_evt_s;
    end
  end

  // Watchdog idle-cycle register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_r <= IDLE_ZERO;
    end else begin
      idle_cnt_r <= idle_next_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .en    (cyc_en_s),
    .q     (mon.num_cycles)
  );

  sat_counter #(.W(CNT_W)) u_instructions (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .en    (ins_en_s),
    .q     (mon.num_instructions)
  );

  sat_counter #(.W(PASS_W)) u_passes (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .en    (pass_en_s),
    .q     (mon.pass_count)
  );

  assign mon.running = running_r;
  assign mon.done    = done_r;
  assign mon.fail    = fail_r;
  assign mon.hang    = hang_r;

endmodule
